// File: rtl/control_sequencer_if.sv
// Bus bundle between the control sequencer and the Phase 1 datapath.
// The sequencer side (master) reads run/IR and drives every strobe;
// the datapath side (slave) sees the mirror image.
interface control_sequencer_if #(
    parameter int NUM_REGS = 16
);
    logic                run;
    logic [31:0]         IR;
    logic [NUM_REGS-1:0] Rin;
    logic [NUM_REGS-1:0] Rout;
    logic                PCout;
    logic                PCin;
    logic                IncPC;
    logic                MARin;
    logic                MDRin;
    logic                MDRout;
    logic                IRin;
    logic                Yin;
    logic                Zin;
    logic                Zlowout;
    logic                Zhighout;
    logic                HIin;
    logic                LOin;
    logic                Read;
    logic [13:0]         alu_op;
    logic                busy;
    logic                halted;
    logic                illegal_op;

    modport master (
        input  run, IR,
        output Rin, Rout, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
               Yin, Zin, Zlowout, Zhighout, HIin, LOin, Read,
               alu_op, busy, halted, illegal_op
    );

    modport slave (
        output run, IR,
        input  Rin, Rout, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
               Yin, Zin, Zlowout, Zhighout, HIin, LOin, Read,
               alu_op, busy, halted, illegal_op
    );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer for the Phase 1 datapath.
// Fetch (T0..T2, T1 stretched by MEM_WAIT), then T3..T6 by opcode class.
// Outputs are a pure decode of the registered state, IR and wait counter.
// Optional macro STEP_MODE_EN adds a `step` input and a PAUSE state that
// holds every instruction at T0 entry until a rising edge of step.
module control_sequencer #(
    parameter int NUM_REGS  = 16,
    parameter int REG_SEL_W = 4,
    parameter int MEM_WAIT  = 0
) (
    input  logic clock,
    input  logic clear,
`ifdef STEP_MODE_EN
    input  logic step,
`endif
    control_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALTED
`ifdef STEP_MODE_EN
        , S_PAUSE
`endif
    } state_t;

`ifdef STEP_MODE_EN
    localparam state_t ENTRY_STATE = S_PAUSE;
`else
    localparam state_t ENTRY_STATE = S_T0;
`endif

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;

    logic [4:0]           opcode;
    logic [REG_SEL_W-1:0] ra_sel, rb_sel, rc_sel;
    logic [NUM_REGS-1:0]  ra_hot, rb_hot, rc_hot;
    logic                 is_binary, is_unary, is_muldiv, is_halt, is_illegal;
    logic [13:0]          alu_vec;
    state_t               done_state;
    logic                 unused_ir_bits;

    logic [NUM_REGS-1:0] rin, rout;
    logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in;
    logic y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in, read;
    logic [13:0] alu_op;
    logic illegal_op;

    // A field value at or beyond NUM_REGS simply matches no bit.
    function automatic logic [NUM_REGS-1:0] sel_onehot(input logic [REG_SEL_W-1:0] sel);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(sel) == i) v[i] = 1'b1;
        end
        return v;
    endfunction

    assign opcode = bus.IR[31:27];
    assign ra_sel = bus.IR[26 -: REG_SEL_W];
    assign rb_sel = bus.IR[26 - REG_SEL_W -: REG_SEL_W];
    assign rc_sel = bus.IR[26 - 2*REG_SEL_W -: REG_SEL_W];
    assign ra_hot = sel_onehot(ra_sel);
    assign rb_hot = sel_onehot(rb_sel);
    assign rc_hot = sel_onehot(rc_sel);
    assign unused_ir_bits = ^bus.IR[26 - 3*REG_SEL_W:0];

    // Opcode class and the one-hot ALU strobe for the current IR.
    always_comb begin
        is_binary = (opcode <= OP_ROL);
        is_unary  = (opcode == OP_NEG) || (opcode == OP_NOT);
        is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
        is_halt   = (opcode == OP_HALT);
        is_illegal = !(is_binary || is_unary || is_muldiv || is_halt || opcode == 5'b11010);
        alu_vec = '0;
        if (is_binary) alu_vec[opcode[3:0]] = 1'b1;
        else if (opcode == OP_NEG) alu_vec[9]  = 1'b1;
        else if (opcode == OP_NOT) alu_vec[10] = 1'b1;
        else if (opcode == OP_MUL) alu_vec[11] = 1'b1;
        else if (opcode == OP_DIV) alu_vec[12] = 1'b1;
    end

    // Next state: fetch, per-class execute steps, and run-gated completion.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        done_state = bus.run ? ENTRY_STATE : S_IDLE;
        case (state_q)
            S_IDLE:   if (bus.run) state_d = ENTRY_STATE;
`ifdef STEP_MODE_EN
            S_PAUSE:  if (step && !step_q) state_d = S_T0;
`endif
            S_T0: begin
                state_d = S_T1;
                wait_d  = '0;
            end
            S_T1: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = S_T2;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_T2:     state_d = S_T3;
            S_T3: begin
                if (is_halt) state_d = S_HALTED;
                else if (is_binary || is_unary || is_muldiv) state_d = S_T4;
                else state_d = done_state;
            end
            S_T4:     state_d = is_unary ? done_state : S_T5;
            S_T5:     state_d = is_muldiv ? S_T6 : done_state;
            S_T6:     state_d = done_state;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    // State and wait-counter registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

`ifdef STEP_MODE_EN
    logic step_q, step_d;
    assign step_d = step;

    // Previous step sample, used to detect its rising edge in PAUSE.
    always_ff @(posedge clock) begin
        if (clear) step_q <= 1'b0;
        else       step_q <= step_d;
    end
`endif

    // Strobe decode of the registered state; everything defaults low.
    always_comb begin
        rin = '0;  rout = '0;  alu_op = '0;
        pc_out = 1'b0; pc_in = 1'b0; inc_pc = 1'b0; mar_in = 1'b0;
        mdr_in = 1'b0; mdr_out = 1'b0; ir_in = 1'b0; y_in = 1'b0; z_in = 1'b0;
        zlow_out = 1'b0; zhigh_out = 1'b0; hi_in = 1'b0; lo_in = 1'b0;
        read = 1'b0; illegal_op = 1'b0;
        case (state_q)
            S_T0: begin pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1; end
            S_T1: begin
                zlow_out = 1'b1; read = 1'b1; mdr_in = 1'b1;
                pc_in    = (wait_q == 4'd0);
            end
            S_T2: begin mdr_out = 1'b1; ir_in = 1'b1; end
            S_T3: begin
                if (is_binary)      begin rout = rb_hot; y_in = 1'b1; end
                else if (is_unary)  begin rout = rb_hot; alu_op = alu_vec; z_in = 1'b1; end
                else if (is_muldiv) begin rout = ra_hot; y_in = 1'b1; end
                else if (is_illegal) illegal_op = 1'b1;
            end
            S_T4: begin
                if (is_binary)      begin rout = rc_hot; alu_op = alu_vec; z_in = 1'b1; end
                else if (is_unary)  begin zlow_out = 1'b1; rin = ra_hot; end
                else if (is_muldiv) begin rout = rb_hot; alu_op = alu_vec; z_in = 1'b1; end
            end
            S_T5: begin
                if (is_binary)      begin zlow_out = 1'b1; rin = ra_hot; end
                else if (is_muldiv) begin zlow_out = 1'b1; lo_in = 1'b1; end
            end
            S_T6: begin zhigh_out = 1'b1; hi_in = 1'b1; end
            default: ;
        endcase
    end

    assign bus.Rin        = rin;
    assign bus.Rout       = rout;
    assign bus.PCout      = pc_out;
    assign bus.PCin       = pc_in;
    assign bus.IncPC      = inc_pc;
    assign bus.MARin      = mar_in;
    assign bus.MDRin      = mdr_in;
    assign bus.MDRout     = mdr_out;
    assign bus.IRin       = ir_in;
    assign bus.Yin        = y_in;
    assign bus.Zin        = z_in;
    assign bus.Zlowout    = zlow_out;
    assign bus.Zhighout   = zhigh_out;
    assign bus.HIin       = hi_in;
    assign bus.LOin       = lo_in;
    assign bus.Read       = read;
    assign bus.alu_op     = alu_op;
    assign bus.illegal_op = illegal_op;
    assign bus.busy       = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign bus.halted     = (state_q == S_HALTED);

endmodule
